// File: rtl/alu181_nibble_sequencer.sv
// Sequences one WIDTH-bit operation through a single 74181 slice wired in
// active-low-data mode, one nibble per pass, least-significant nibble first.
// Carry is chained from Cn+4 back into Cn between passes. Partial nibbles build
// up in a shadow register, and the visible results change only on entry to FINISH.
// Optional feature: define NIBBLE_GP_EN to add per-nibble ~G/~P capture.
module alu181_nibble_sequencer #(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned SETTLE  = 1,
  localparam int unsigned WIDTH  = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             aeqb,
  output logic             alu_cn,
  output logic [3:0]       alu_a_n,
  output logic [3:0]       alu_b_n,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  input  logic [3:0]       alu_f_n,
  input  logic             alu_cn4,
  input  logic             alu_aeqb
`ifdef NIBBLE_GP_EN
  ,
  input  logic             alu_g_n,
  input  logic             alu_p_n,
  output logic [NIBBLES-1:0] gp_g_n,
  output logic [NIBBLES-1:0] gp_p_n
`endif
);

  localparam int unsigned KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [3:0] SettleCnt = 4'(SETTLE);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StFinish} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_lat_q, b_lat_q;
  logic [KW-1:0]    k_q, k_nx;
  logic [3:0]       cnt_q;
  logic             carry_q;
  logic             acc_q, acc_nx;
  logic [WIDTH-1:0] shadow_q, shadow_nx;
  logic             last_nib;

  assign k_nx     = k_q + 1'b1;
  assign last_nib = (k_q == KW'(NIBBLES - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StDrive;
      StDrive:  if (cnt_q == SettleCnt) state_d = StSample;
      StSample: state_d = last_nib ? StFinish : StDrive;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state_q == StDrive) || (state_q == StSample);
    done = (state_q == StFinish);
  end

  // Merge the nibble being sampled into the shadow copy and the A=B accumulator
  always_comb begin
    shadow_nx                = shadow_q;
    shadow_nx[4*k_q +: 4]    = ~alu_f_n;
    acc_nx                   = (k_q == '0) ? alu_aeqb : (acc_q & alu_aeqb);
  end

  // Operand latch, pass control, ALU pin drive and result publication
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_lat_q  <= '0;
      b_lat_q  <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      acc_q    <= 1'b0;
      shadow_q <= '0;
      result   <= '0;
      cout     <= 1'b0;
      aeqb     <= 1'b0;
      alu_a_n  <= 4'hF;
      alu_b_n  <= 4'hF;
      alu_s    <= 4'h0;
      alu_m    <= 1'b0;
      alu_cn   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_lat_q <= a;
            b_lat_q <= b;
            k_q     <= '0;
            cnt_q   <= '0;
            carry_q <= cin;
            // ALU pins are loaded on DRIVE entry so they are stable through SAMPLE
            alu_a_n <= ~a[3:0];
            alu_b_n <= ~b[3:0];
            alu_s   <= s;
            alu_m   <= m;
            alu_cn  <= cin;
          end
        end
        StDrive: begin
          cnt_q <= (cnt_q == SettleCnt) ? 4'h0 : cnt_q + 4'h1;
        end
        StSample: begin
          shadow_q <= shadow_nx;
          carry_q  <= alu_cn4;
          acc_q    <= acc_nx;
          if (last_nib) begin
            // Visible results change together, in the cycle done is high
            result <= shadow_nx;
            cout   <= alu_cn4;
            aeqb   <= acc_nx;
          end else begin
            k_q     <= k_nx;
            alu_a_n <= ~a_lat_q[4*k_nx +: 4];
            alu_b_n <= ~b_lat_q[4*k_nx +: 4];
            alu_cn  <= alu_cn4;
          end
        end
        StFinish: ;
        default: ;
      endcase
    end
  end

`ifdef NIBBLE_GP_EN
  logic [NIBBLES-1:0] g_sh_q, p_sh_q, g_sh_nx, p_sh_nx;

  // Place this pass's ~G/~P levels at bit k
  always_comb begin
    g_sh_nx      = g_sh_q;
    p_sh_nx      = p_sh_q;
    g_sh_nx[k_q] = alu_g_n;
    p_sh_nx[k_q] = alu_p_n;
  end

  // Capture ~G/~P per nibble, publish alongside the other results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_sh_q <= '1;
      p_sh_q <= '1;
      gp_g_n <= '1;
      gp_p_n <= '1;
    end else if (state_q == StSample) begin
      g_sh_q <= g_sh_nx;
      p_sh_q <= p_sh_nx;
      if (last_nib) begin
        gp_g_n <= g_sh_nx;
        gp_p_n <= p_sh_nx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu181_nibble_sequencer.sv
// Bench for alu181_nibble_sequencer (NIBBLES=4, SETTLE=1). A pin-level 74181
// model answers the sequencer; expected results come from a word-level model.
module tb_alu181_nibble_sequencer;

  localparam int LAT = 13;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] a, b;
  logic [3:0]  s;
  logic        m, cin;
  logic        busy, done, cout, aeqb;
  logic [15:0] result;
  logic        alu_cn, alu_m;
  logic [3:0]  alu_a_n, alu_b_n, alu_s;
  logic [3:0]  alu_f_n;
  logic        alu_cn4, alu_aeqb;

  int errors = 0;
  int checks = 0;
  logic [3:0] cn_seen;

  always #5 clk = ~clk;

  alu181_nibble_sequencer #(.NIBBLES(4), .SETTLE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .s(s), .m(m), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .aeqb(aeqb),
    .alu_cn(alu_cn), .alu_a_n(alu_a_n), .alu_b_n(alu_b_n), .alu_s(alu_s), .alu_m(alu_m),
    .alu_f_n(alu_f_n), .alu_cn4(alu_cn4), .alu_aeqb(alu_aeqb)
  );

  // 74181 on its pins, native active-high reading: Cn low = carry in,
  // Cn+4 low = carry out, A=B high when all F pins are high.
  logic [3:0] px, py;
  logic [4:0] psum;
  always_comb begin
    px       = alu_a_n | ({4{alu_s[0]}} & alu_b_n) | ({4{alu_s[1]}} & ~alu_b_n);
    py       = ({4{alu_s[2]}} & alu_a_n & ~alu_b_n) | ({4{alu_s[3]}} & alu_a_n & alu_b_n);
    psum     = {1'b0, px} + {1'b0, py} + {4'b0, ~alu_cn};
    alu_f_n  = alu_m ? ~(px ^ py) : psum[3:0];
    alu_cn4  = ~psum[4];
    alu_aeqb = &alu_f_n;
  end

  // Whole-word reference in true polarity (active-low-data function table)
  function automatic logic [17:0] ref_op(input logic [15:0] ta, tb, input logic [3:0] ts,
                                         input logic tm, tc);
    logic [15:0] xt, yt, r;
    logic [16:0] sum;
    xt  = ta & ~({16{ts[0]}} & ~tb) & ~({16{ts[1]}} & tb);
    yt  = ~(({16{ts[2]}} & ~ta & tb) | ({16{ts[3]}} & ~ta & ~tb));
    sum = {1'b0, xt} + {1'b0, yt} + {16'b0, tc};
    r   = tm ? (xt ^ yt) : sum[15:0];
    return {(r == 16'h0), sum[16], r};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // One operation; watches that result never changes and busy stays high while running
  task automatic run_op(input logic [15:0] ta, tb, input logic [3:0] ts, input logic tm, tc,
                        output logic [15:0] r, output logic co, eq, output int lat,
                        output logic clean);
    logic [15:0] held;
    @(negedge clk);
    a = ta; b = tb; s = ts; m = tm; cin = tc; start = 1'b1;
    held = result; clean = 1'b1; lat = 0; cn_seen = 4'bx;
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (!done && lat < 100) begin
      if (result !== held || busy !== 1'b1) clean = 1'b0;
      if ((lat - 1) % 3 == 0 && (lat - 1) / 3 < 4) cn_seen[(lat - 1) / 3] = alu_cn;
      @(negedge clk);
      lat++;
    end
    r = result; co = cout; eq = aeqb;
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic [3:0]  s;
    logic        m, cin;
    logic [15:0] res;
    logic        cout, aeqb;
  } vec_t;

  initial begin
    vec_t        vecs[8];
    logic [15:0] r, ta, tb, r13, r27;
    logic [3:0]  ts;
    logic        co, eq, clean, tm, tc;
    logic [17:0] exp;
    int          lat, dcount, d1, d2;

    vecs[0] = '{16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[2] = '{16'h0100, 16'h0001, 4'b0110, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0};
    vecs[3] = '{16'hFFFF, 16'h0000, 4'b0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFE, 16'h0000, 4'b0000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
    vecs[5] = '{16'hABCD, 16'h1234, 4'b1111, 1'b0, 1'b0, 16'hABCD, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[7] = '{16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_aeqb", aeqb, 0);
    check("rst_alu_a_n", alu_a_n, 4'hF);
    check("rst_alu_b_n", alu_b_n, 4'hF);
    check("rst_alu_s", alu_s, 0);
    check("rst_alu_m", alu_m, 0);
    check("rst_alu_cn", alu_cn, 0);
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].cin, r, co, eq, lat, clean);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_cout", i), co, vecs[i].cout);
      check($sformatf("vec%0d_aeqb", i), eq, vecs[i].aeqb);
      check($sformatf("vec%0d_latency", i), lat, LAT);
      check($sformatf("vec%0d_no_partial", i), clean, 1);
      if (i == 1) check("carry_chain_cn_1to3", cn_seen[3:1], 3'b111);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), done, 0);
    end

    // Reset in the second DRIVE pass aborts the operation
    run_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, r, co, eq, lat, clean);
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; s = 4'b1001; m = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_alu_a_n", alu_a_n, 4'hF);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    run_op(16'h0100, 16'h0001, 4'b0110, 1'b0, 1'b1, r, co, eq, lat, clean);
    check("after_abort_result", r, 16'h00FF);
    check("after_abort_latency", lat, LAT);

    // Starts while busy / in FINISH ignored; start right after done accepted
    @(negedge clk);
    a = 16'h1234; b = 16'h0FFF; s = 4'b1001; m = 1'b0; cin = 1'b0; start = 1'b1;
    dcount = 0; d1 = -1; d2 = -1; r13 = 'x; r27 = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        if (d1 < 0) begin d1 = c; r13 = result; end
        else begin d2 = c; r27 = result; end
      end
      start = (c == 3 || c == 8 || c == 13 || c == 14);
      if (c == 14) begin
        a = 16'h0100; b = 16'h0001; s = 4'b0110; m = 1'b0; cin = 1'b1;
      end else if (start) begin
        a = 16'($urandom); b = 16'($urandom); s = 4'($urandom); m = 1'b1; cin = 1'b1;
      end
    end
    check("b2b_done_count", dcount, 2);
    check("b2b_first_done_cycle", d1, LAT);
    check("b2b_second_done_cycle", d2, 14 + LAT);
    check("b2b_first_result", r13, 16'h2233);
    check("b2b_second_result", r27, 16'h00FF);

    // Random operations against the word-level reference
    for (int i = 0; i < 40; i++) begin
      ta = 16'($urandom);
      tb = (i % 5 == 0) ? ta : 16'($urandom);
      ts = 4'($urandom_range(0, 15));
      tm = 1'($urandom);
      tc = 1'($urandom);
      exp = ref_op(ta, tb, ts, tm, tc);
      run_op(ta, tb, ts, tm, tc, r, co, eq, lat, clean);
      check($sformatf("rnd%0d_result", i), r, exp[15:0]);
      check($sformatf("rnd%0d_cout", i), co, exp[16]);
      check($sformatf("rnd%0d_aeqb", i), eq, exp[17]);
      check($sformatf("rnd%0d_latency", i), lat, LAT);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu181_nibble_sequencer.md
Name: alu181_nibble_sequencer

Overview:
- Drives a single 74181 4-bit ALU slice over NIBBLES passes to perform one WIDTH-bit operation, least-significant nibble first.
- Latches operands and the function select, presents one nibble per pass, waits SETTLE cycles, then samples the ALU outputs.
- Chains carry from Cn+4 back into Cn between passes and assembles the full result.
- Sits between a requesting controller or bench and a 74181 device (chip model or socketed part) wired in active-low-data mode.

Parameters:
NIBBLES, 4, number of 4-bit passes per operation; WIDTH = 4*NIBBLES
SETTLE, 1, idle cycles after driving a nibble before sampling; legal range 0..15

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; accepted only in IDLE
a  in  WIDTH  operand A, true polarity
b  in  WIDTH  operand B, true polarity
s  in  4  function select, per the 74181 active-low-data table
m  in  1  mode: 1 = logic, 0 = arithmetic
cin  in  1  carry in, active-high (1 = carry)
busy  out  1  operation in progress
done  out  1  one-cycle pulse; results valid from this cycle
result  out  WIDTH  true-polarity result, held until next done
cout  out  1  final Cn+4 level (1 = carry out)
aeqb  out  1  AND of sampled A=B over all nibbles
alu_cn  out  1  to ALU Cn
alu_a_n  out  4  to ALU ~A3..~A0
alu_b_n  out  4  to ALU ~B3..~B0
alu_s  out  4  to ALU S3..S0
alu_m  out  1  to ALU M
alu_f_n  in  4  from ALU ~F3..~F0
alu_cn4  in  1  from ALU Cn+4
alu_aeqb  in  1  from ALU A=B; caller provides the pull-up

Behaviour:
- Reset values:
  - busy=0, done=0, result=0, cout=0, aeqb=0.
  - alu_a_n=4'hF, alu_b_n=4'hF, alu_s=0, alu_m=0, alu_cn=0.
  - FSM in IDLE, nibble index k=0, settle counter=0.
- Reset asserted mid-operation aborts immediately: no done pulse, result returns to 0.
- FSM states: IDLE -> DRIVE -> SAMPLE -> (DRIVE | FINISH) -> IDLE.
- IDLE:
  - On start=1, latch a, b, s, m, cin.
  - Set k=0 and carry register = cin; set busy=1 next cycle; go to DRIVE.
  - start while busy is ignored; it is neither queued nor errored.
- DRIVE:
  - alu_a_n = ~a_latched[4k+3:4k]; alu_b_n = ~b_latched[4k+3:4k].
  - alu_s and alu_m = latched values; alu_cn = carry register.
  - Stay SETTLE cycles (counter), then go to SAMPLE. SETTLE=0 means one DRIVE cycle.
  - ALU inputs stay stable from DRIVE entry through SAMPLE.
- SAMPLE (one cycle):
  - result[4k+3:4k] <= ~alu_f_n.
  - carry register <= alu_cn4.
  - aeqb accumulator <= (k==0 ? alu_aeqb : acc & alu_aeqb).
  - If k==NIBBLES-1, go to FINISH; else k <= k+1 and go to DRIVE.
- FINISH (one cycle):
  - done=1; cout = carry register; aeqb = accumulator; busy=0.
  - Go to IDLE. A start in the FINISH cycle is ignored.
- result, cout and aeqb are updated only at FINISH.
  - Partial nibbles go to a shadow register, so result never shows a half-computed value.
- Latency, start to done pulse: 1 + NIBBLES*(SETTLE+2) cycles. NIBBLES=4, SETTLE=1 gives 13.
- Carry polarity: active-low-data convention, so Cn=H and Cn+4=H mean carry. The sequencer passes carry levels through unmodified.
- In logic mode (m=1) carry still chains, but cout is the meaningless Cn+4 level; it is not masked.
- alu_* outputs hold their last driven values in IDLE; they return to reset values only on reset.

Optional Feature:
NIBBLE_GP_EN
- Defined:
  - Adds inputs alu_g_n and alu_p_n (1 bit each).
  - Adds outputs gp_g_n and gp_p_n (NIBBLES bits each).
  - Bit k captures the ~G and ~P levels in SAMPLE for nibble k; outputs update at FINISH with the other results.
  - Reset value of both outputs is all ones.
- Undefined: the ports do not exist and no capture logic is built.

Test Plan:
- Reset mid-op: assert reset in the 2nd DRIVE -> busy=0, done never pulses, result=0, alu_a_n=4'hF; a new start then completes normally.
- Add: a=16'h1234, b=16'h0FFF, s=4'b1001, m=0, cin=0 -> done at cycle 13 after start, result=16'h2233, cout=0.
- Add with carry out: a=16'hFFFF, b=16'h0001, s=4'b1001, m=0, cin=0 -> result=16'h0000, cout=1. Confirm alu_cn=1 in nibbles 1..3.
- Subtract: a=16'h0100, b=16'h0001, s=4'b0110, m=0, cin=1 -> result=16'h00FF, cout=1 (no borrow).
- A=B accumulation: m=1, s=4'b0000 (F = NOT A):
  - a=16'hFFFF -> result=16'h0000, aeqb=1.
  - a=16'hFFFE -> aeqb=0.
- Busy start and back-to-back: pulse start at cycles 3 and 8 during an operation -> ignored, one done only. A start the cycle after done is accepted.
